// File: rtl/mac_array_seq.sv
// mac_array_seq: sequencer for the 8-MAC / 4-output MAC array.
// For each output pixel it streams nchunk operand-buffer reads into the array,
// accumulates the four returned partial sums, then offers the pixel on a
// valid/ready port. Handshake: a result transfers on a rising edge where
// out_vld and out_rdy are both high; out_vld, out_data_* and out_pix hold
// steady until then.
module mac_array_seq #(
    parameter int MAC_LAT = 3,
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 10,
    parameter int PSUM_W  = 20,
    parameter int ACC_W   = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_nchunk,
    input  logic [CNT_W-1:0]  cfg_npix,
    output logic              busy,
    output logic              done,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    output logic              mac_vld_i,
    input  logic              mac_vld_o,
    input  logic [PSUM_W-1:0] psum_0,
    input  logic [PSUM_W-1:0] psum_1,
    input  logic [PSUM_W-1:0] psum_2,
    input  logic [PSUM_W-1:0] psum_3,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [ACC_W-1:0]  out_data_0,
    output logic [ACC_W-1:0]  out_data_1,
    output logic [ACC_W-1:0]  out_data_2,
    output logic [ACC_W-1:0]  out_data_3,
    output logic [CNT_W-1:0]  out_pix
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_OUT   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0]  nchunk;
    logic [CNT_W-1:0]  npix;
    logic [CNT_W-1:0]  chunk;
    logic [CNT_W-1:0]  ret;
    logic [CNT_W-1:0]  pix;
    logic [ADDR_W-1:0] addr;
    logic              vld_i_q;
    logic [ACC_W-1:0]  acc [4];
    logic [PSUM_W-1:0] psum [4];

    logic cfg_zero;
    logic last_chunk;
    logic ret_hit;
    logic last_ret;
    logic last_pix;

    assign psum[0] = psum_0;
    assign psum[1] = psum_1;
    assign psum[2] = psum_2;
    assign psum[3] = psum_3;

    assign cfg_zero   = (cfg_nchunk == '0) || (cfg_npix == '0);
    assign last_chunk = (chunk == nchunk - CNT_W'(1));
    // Returns count in ISSUE as well as DRAIN; stray returns elsewhere are dropped.
    assign ret_hit    = mac_vld_o && ((state == S_ISSUE) || (state == S_DRAIN));
    assign last_ret   = ret_hit && (ret == nchunk - CNT_W'(1));
    assign last_pix   = (pix == npix - CNT_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        buf_rd_en = 1'b0;
        out_vld   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = cfg_zero ? S_FIN : S_ISSUE;
            end
            S_ISSUE: begin
                busy      = 1'b1;
                buf_rd_en = 1'b1;
                if (last_chunk) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (last_ret) state_nx = S_OUT;
            end
            S_OUT: begin
                busy    = 1'b1;
                out_vld = 1'b1;
                if (out_rdy) state_nx = last_pix ? S_FIN : S_ISSUE;
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Config capture, counters, read address and accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            nchunk  <= '0;
            npix    <= '0;
            chunk   <= '0;
            ret     <= '0;
            pix     <= '0;
            addr    <= '0;
            vld_i_q <= 1'b0;
            for (int k = 0; k < 4; k++) acc[k] <= '0;
        end else begin
            // Read data arrives one cycle after the strobe.
            vld_i_q <= (state == S_ISSUE);
            if ((state == S_IDLE) && start) begin
                nchunk <= cfg_nchunk;
                npix   <= cfg_npix;
                pix    <= '0;
                addr   <= '0;
                chunk  <= '0;
                ret    <= '0;
            end
            if (state == S_ISSUE) begin
                addr  <= addr + ADDR_W'(1);
                chunk <= last_chunk ? '0 : chunk + CNT_W'(1);
            end
            if (ret_hit) begin
                ret <= last_ret ? '0 : ret + CNT_W'(1);
                for (int k = 0; k < 4; k++) begin
                    if (ret == '0)
                        acc[k] <= {{(ACC_W-PSUM_W){psum[k][PSUM_W-1]}}, psum[k]};
                    else
                        acc[k] <= acc[k] + {{(ACC_W-PSUM_W){psum[k][PSUM_W-1]}}, psum[k]};
                end
            end
            if ((state == S_OUT) && out_rdy && !last_pix) pix <= pix + CNT_W'(1);
        end
    end

    assign buf_rd_addr = addr;
    assign mac_vld_i   = vld_i_q;
    assign out_data_0  = acc[0];
    assign out_data_1  = acc[1];
    assign out_data_2  = acc[2];
    assign out_data_3  = acc[3];
    assign out_pix     = pix;

endmodule

// File: doc/mac_array_seq.md
Name: mac_array_seq

Overview:
- Sequencer for the 8-MAC / 4-output MAC array.
- On a start pulse it streams input-channel chunks from the operand buffer into the array, one chunk per cycle.
- It accumulates the array's four 20-bit partial sums across all chunks of one output pixel, then presents the four pixel sums on a valid/ready output port.
- Repeats for a configured number of output pixels; sits between the layer controller (start/config/done) and the post-processing stage (bias/quantize).

Parameters:
MAC_LAT, 3, cycles from array vld_i to array vld_o (fixed array latency)
ADDR_W, 10, operand buffer address width
CNT_W, 10, width of chunk and pixel counters/config fields
PSUM_W, 20, width of each array partial-sum output
ACC_W, 28, width of each pixel accumulator/output

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle start pulse; honoured only in IDLE
cfg_nchunk  in  CNT_W  chunks per output pixel; sampled on accepted start
cfg_npix  in  CNT_W  output pixels per run; sampled on accepted start
busy  out  1  high from the cycle after an accepted start until FIN
done  out  1  one-cycle pulse at end of run
buf_rd_en  out  1  operand buffer read strobe; buffer read latency = 1
buf_rd_addr  out  ADDR_W  read address, linear = pix*nchunk + chunk
mac_vld_i  out  1  array input valid; buf_rd_en delayed by 1 cycle
mac_vld_o  in  1  array output valid
psum_0..psum_3  in  PSUM_W each  array partial sums, two's complement
out_vld  out  1  pixel result valid
out_rdy  in  1  downstream ready
out_data_0..out_data_3  out  ACC_W each  pixel sums, two's complement
out_pix  out  CNT_W  index of the pixel on out_data

Behaviour:
- Reset (rst=1 at a clock edge, any state):
  - state=IDLE; all counters, accumulators and outputs 0.
  - busy, done, buf_rd_en, mac_vld_i and out_vld are 0.
- IDLE:
  - start=1 latches cfg into registers and resets pix counter and address to 0.
  - If either cfg field is 0, go to FIN (no reads issued, no output); otherwise go to ISSUE.
  - start outside IDLE is ignored.
- ISSUE:
  - buf_rd_en=1 each cycle; buf_rd_addr increments by 1 per cycle.
  - Exactly nchunk reads per pixel, then go to DRAIN.
- mac_vld_i: registered copy of buf_rd_en, aligned with read data at the array inputs.
- DRAIN:
  - Each mac_vld_o=1 cycle increments the return counter.
  - On the first return of a pixel, acc_k <= sign-extended psum_k; on later returns, acc_k <= acc_k + sign-extended psum_k.
  - When the return count reaches nchunk (counting the current return), go to OUT.
- Return accounting across states:
  - Returns arriving while still in ISSUE are accumulated identically; the return counter runs independently of state.
  - mac_vld_o in IDLE, OUT or FIN is ignored.
- Arithmetic: wraps modulo 2^ACC_W, no saturation.
- OUT:
  - out_vld=1; out_data_k=acc_k; out_pix=current pix.
  - All held stable while out_rdy=0.
  - On out_vld & out_rdy: if pix == npix-1, go to FIN; else increment pix and go to ISSUE. Address continues linearly.
- FIN:
  - done=1 and busy=0 for exactly one cycle, then go to IDLE.
  - A start in the FIN cycle is ignored.
- Timing for nchunk=N, start accepted at edge of cycle T:
  - buf_rd_en high cycles T+1..T+N.
  - mac_vld_i high cycles T+2..T+N+1.
  - mac_vld_o expected T+2+MAC_LAT..T+N+1+MAC_LAT.
  - out_vld first high at T+N+2+MAC_LAT.
- No overlap: the next pixel's reads start the cycle after the output handshake.

Test Plan:
- Reset then start, nchunk=1, npix=1, psum_0..3 = 5,-3,100,0 -> one rd_en at addr 0, mac_vld_i one cycle later, out_data = 5,-3,100,0; out_vld at T+1+2+MAC_LAT; done pulse 1 cycle after handshake, out_rdy=1.
- nchunk=3, npix=1, psum_0 returns 524287, 524287, -524288 (other lanes 1,2,3) -> addr 0,1,2; out_data_0=524286 (sign-extended, no overflow), other lanes 3,6,9.
- nchunk=2, npix=3, out_rdy low 4 cycles on pixel 1 -> addresses 0..5 in order; out_data/out_pix=1 stable while stalled; no rd_en during stall; done after pix 2 handshake.
- cfg_nchunk=0 (or cfg_npix=0) with start -> no rd_en, no out_vld; done pulses the cycle after start; busy never high.
- rst=1 mid-DRAIN of a 4-chunk pixel, then late mac_vld_o pulses -> all outputs 0 the next cycle; stray vld_o ignored in IDLE; a fresh start yields correct sums.
- start pulses during ISSUE and OUT -> ignored; cfg changes after start have no effect on the run.
